// File: rtl/is_uart_rx_sampler.sv
// is_uart_rx_sampler: synchronises and deglitches the UART rx pin and
// generates bit-centre sample strobes re-aligned to each start bit.
module is_uart_rx_sampler #(
  parameter int DIV_W = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_EN = 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             rxd_i,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic             rxct_r_i,
  output logic             rxd_rg_o,
  output logic             rx_ce_o,
  output logic             cfg_err_o
);
  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(4);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   y;
  logic                   maj;
  logic [DIV_W-1:0]       div_q;
  logic [DIV_W-1:0]       cnt;
  logic [DIV_W-1:0]       cnt_d;
  logic                   ce_d;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) sync_q <= '1;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], rxd_i};
  assign y = sync_q[SYNC_STAGES-1];
  generate
    if (FILT_EN != 0) begin : g_filt
      logic w0, w1;
      always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) {w1, w0} <= 2'b11;
        else {w1, w0} <= {w0, y};
      assign maj = (y & w0) | (y & w1) | (w0 & w1);
    end else begin : g_byp
      assign maj = y;
    end
  endgenerate
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) rxd_rg_o <= 1'b1;
    else rxd_rg_o <= maj;
  // divisor is only sampled while the FSM holds the counter, so frames never see a change
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      div_q <= MIN_DIV;
      cfg_err_o <= 1'b0;
    end else if (rxct_r_i) begin
      div_q <= (baud_div_i < MIN_DIV) ? MIN_DIV : baud_div_i;
      cfg_err_o <= baud_div_i < MIN_DIV;
    end
  always_comb begin
    ce_d = !rxct_r_i && cnt == '0;
    cnt_d = rxct_r_i ? (div_q >> 1) - DIV_W'(1) : ce_d ? div_q - DIV_W'(1) : cnt - DIV_W'(1);
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      cnt <= '0;
      rx_ce_o <= 1'b0;
    end else begin
      cnt <= cnt_d;
      rx_ce_o <= ce_d;
    end
endmodule

// File: tb/tb_is_uart_rx_sampler.sv
// tb_is_uart_rx_sampler: random frames and line noise, expected edges/strobes
// queued by a cycle-level reference model and consumed by a monitor.
module tb_is_uart_rx_sampler;
  localparam int S = 2;
  typedef struct {int c; logic v;} edge_t;
  logic clk = 0, rstn = 0, rxd_i = 1, rxct_r_i = 1;
  logic [15:0] baud_div_i = 16;
  logic rxd_rg_o, rx_ce_o, cfg_err_o;
  edge_t rgq[$];
  int ceq[$];
  logic hist[$];
  int cyc = -1, checks = 0, failures = 0;
  logic mon_en = 0, exp_err = 0, lvl = 1, last_exp = 1, m_ce;
  logic prev_r = 1;
  int prev_b = 16, k = 0, dq = 4, hh = 2, run_left = 0;
  logic cur = 1;

  is_uart_rx_sampler #(.DIV_W(16), .SYNC_STAGES(S), .FILT_EN(1)) dut (
    .clk_i(clk), .rstn_i(rstn), .rxd_i(rxd_i), .baud_div_i(baud_div_i),
    .rxct_r_i(rxct_r_i), .rxd_rg_o(rxd_rg_o), .rx_ce_o(rx_ce_o), .cfg_err_o(cfg_err_o));

  always #5 clk = ~clk;

  function automatic logic hv(int i);
    return (i < 0) ? 1'b1 : hist[i];
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, act, exp);
    end
  endtask

  // model: filtered line = majority of three consecutive delayed samples;
  // strobes at k+H+m*D counted from the first low cycle k of each run
  task automatic drive(input logic dv, input logic rv, input int bv);
    int t;
    logic e;
    @(posedge clk);
    #1;
    cyc++;
    rxd_i = dv; rxct_r_i = rv; baud_div_i = bv[15:0];
    hist.push_back(dv);
    t = int'(hv(cyc-S-1)) + int'(hv(cyc-S-2)) + int'(hv(cyc-S-3));
    e = t >= 2;
    if (e != last_exp) begin
      rgq.push_back('{cyc, e});
      last_exp = e;
    end
    if (prev_r) exp_err = prev_b < 4;
    if (!rv) begin
      if (prev_r) begin
        k = cyc; dq = (prev_b < 4) ? 4 : prev_b; hh = dq / 2;
      end
      t = cyc + 1 - k - hh;
      if (t >= 0 && t % dq == 0) ceq.push_back(cyc + 1);
    end
    prev_r = rv; prev_b = bv;
  endtask

  task automatic nrx(output logic v);
    if (run_left == 0) begin
      cur = ~cur;
      run_left = int'($urandom_range(1, 6));
    end
    run_left--;
    v = cur;
  endtask

  function automatic int rbaud();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 20));
  endfunction

  always @(negedge clk) if (mon_en) begin
    while (rgq.size() > 0 && rgq[0].c < cyc) begin
      chk("rxd_rg_edge_missed", rxd_rg_o, rgq[0].v);
      lvl = rgq[0].v;
      void'(rgq.pop_front());
    end
    if (rgq.size() > 0 && rgq[0].c == cyc) begin
      lvl = rgq[0].v;
      void'(rgq.pop_front());
    end
    chk("rxd_rg", rxd_rg_o, lvl);
    while (ceq.size() > 0 && ceq[0] < cyc) begin
      chk("rx_ce_missed", rx_ce_o, 1'b1);
      void'(ceq.pop_front());
    end
    m_ce = ceq.size() > 0 && ceq[0] == cyc;
    if (m_ce) void'(ceq.pop_front());
    chk("rx_ce", rx_ce_o, m_ce);
    chk("cfg_err", cfg_err_o, exp_err);
  end

  initial begin
    int b, b2, len, k0;
    logic v;
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1;
    drive(1, 1, 16);
    mon_en = 1;
    repeat (100) drive(1, 1, 16);
    repeat (60) begin
      b = rbaud();
      repeat ($urandom_range(2, 6)) begin nrx(v); drive(v, 1, b); end
      dq = (b < 4) ? 4 : b;
      hh = dq / 2;
      len = ($urandom_range(0, 1) == 0) ? hh + int'($urandom_range(0, 3)) * dq - 1
                                         : int'($urandom_range(1, 3)) * dq + hh + 3;
      repeat (len) begin
        b2 = ($urandom_range(0, 3) == 0) ? rbaud() : b;
        nrx(v);
        drive(v, 0, b2);
      end
    end
    repeat (8) drive(1, 1, 16);
    repeat (3) drive(0, 1, 2);
    k0 = cyc + 1;
    repeat (11) drive(0, 0, 2);
    if (cyc != k0 + 10) chk("dir_cycle", 1'b0, 1'b1);
    @(negedge clk);
    #2;
    mon_en = 0;
    rstn = 0;
    #1;
    chk("rst_rx_ce", rx_ce_o, 1'b0);
    chk("rst_rxd_rg", rxd_rg_o, 1'b1);
    chk("rst_cfg_err", cfg_err_o, 1'b0);
    @(negedge clk) rstn = 1;
    rxd_i = 1; rxct_r_i = 1; baud_div_i = 16;
    @(posedge clk);
    #1;
    chk("post_rst_rx_ce", rx_ce_o, 1'b0);
    chk("post_rst_rxd_rg", rxd_rg_o, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/is_uart_rx_sampler.md
Name: is_uart_rx_sampler

Overview:
Front end of the UART receive path, directly upstream of the receive frame FSM.
- Synchronises the asynchronous serial pin into clk_i and removes single-cycle glitches, producing rxd_rg_o.
- Generates the bit-centre sample strobe rx_ce_o from a runtime baud divisor.
- Re-aligns the strobe to the middle of the start bit whenever the FSM releases the counter hold (rxct_r_i low).
- rxd_rg_o, rx_ce_o and rxct_r_i connect one-to-one to the FSM's rxd_rg_i, rx_ce_i and rxct_r_o.

Parameters:
DIV_W, 16, width of the baud divisor and bit counter.
SYNC_STAGES, 2, number of metastability flops on rxd_i (legal range 2..4).
FILT_EN, 1, 1 = 3-sample majority glitch filter present; 0 = filter bypassed.

Ports:
clk_i  in  1  system clock.
rstn_i  in  1  reset, asynchronous, active-low.
rxd_i  in  1  raw serial line, asynchronous, idle high.
baud_div_i  in  DIV_W  clocks per bit N (quasi-static).
rxct_r_i  in  1  counter hold from the FSM; 1 = idle/hold, 0 = frame in progress.
rxd_rg_o  out  1  synchronised, filtered serial data.
rx_ce_o  out  1  one-cycle sample strobe at bit centres.
cfg_err_o  out  1  divisor out of range (clamped).

Behaviour:
Reset values:
- All sync flops, filter taps and rxd_rg_o = 1.
- rx_ce_o = 0, cfg_err_o = 0.
- cnt = 0; div_q = 4.

Synchroniser:
- rxd_i passes through a SYNC_STAGES flop chain; the last stage is y.

Filter (FILT_EN=1):
- Taps w0 = y delayed 1 cycle, w1 = y delayed 2 cycles.
- Registered output: rxd_rg_o <= maj(y, w0, w1).
- A level change on y appears on rxd_rg_o 2 cycles later.
- Total latency rxd_i to rxd_rg_o = SYNC_STAGES+2 cycles.
- A y pulse of 1 cycle is rejected; a pulse of 2 or more cycles passes.

Filter bypass (FILT_EN=0):
- rxd_rg_o <= y; latency SYNC_STAGES+1.

Divisor latch:
- While rxct_r_i=1, every cycle: div_q <= max(baud_div_i, 4) and cfg_err_o <= (baud_div_i < 4).
- div_q is frozen while rxct_r_i=0, so a divisor change mid-frame has no effect until the next hold.
- H = div_q >> 1 (floor).

Bit counter (down-counter cnt, DIV_W bits):
- rxct_r_i=1: cnt <= H-1 and rx_ce_o <= 0. The hold has priority over everything, including a pending zero.
- rxct_r_i=0 and cnt!=0: cnt <= cnt-1 and rx_ce_o <= 0.
- rxct_r_i=0 and cnt==0: cnt <= div_q-1 and rx_ce_o <= 1.

Strobe timing:
- If cycle k is the first cycle with rxct_r_i=0, the first strobe is high in cycle k+H.
- Later strobes fall at k+H+m*div_q, m >= 1, each exactly 1 cycle wide.
- There is never a strobe in a cycle directly following a cycle with rxct_r_i=1.

Hold mid-frame:
- If rxct_r_i rises mid-frame (FSM abort or end of frame), the counter reloads in the same cycle.
- No further strobe occurs.

Odd divisor:
- H is floored; the period stays exactly div_q.

Reset mid-operation:
- All state returns to reset values asynchronously.
- The first cycle after release behaves as hold, with rxd_rg_o = 1.

Test Plan:
- Reset, rxd_i=1 and baud_div_i=16 constant -> rxd_rg_o=1 and rx_ce_o=0 for 100 cycles; cfg_err_o=0.
- rxd_i 1->0 step at cycle 10 (SYNC_STAGES=2, FILT_EN=1) -> rxd_rg_o falls in cycle 14; a 1-cycle low glitch on y produces no change on rxd_rg_o.
- baud_div_i=16, rxct_r_i driven 0 from cycle 20 -> rx_ce_o high in cycles 28, 44, 60, 76, each 1 cycle wide.
- baud_div_i=15, rxct_r_i low from cycle 0 -> strobes at 7, 22, 37; baud_div_i changed to 8 mid-frame -> period stays 15 until rxct_r_i=1.
- rxct_r_i raised in the cycle cnt reaches 0 -> no rx_ce_o the next cycle; lowering again at cycle k -> first strobe at k+H.
- baud_div_i=2 during hold -> cfg_err_o=1 and div_q=4, strobes at k+2, k+6, k+10. Also: rstn_i pulsed low mid-frame -> rx_ce_o=0 and rxd_rg_o=1 immediately.
- Loopback with the receive FSM at N=16, frame 0xA5 -> FSM accepts the frame with data 0xA5.
